// File: rtl/kbd_joy_input_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : input_pkg                                                     |
// | Purpose  : Shared constants for the keyboard/joystick input stage:       |
// |            joystick bit positions, PS/2 key codes, key-state indices,    |
// |            coin FSM state encoding and small decode helpers.             |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package input_pkg;

  // Joystick word bit positions (same layout for both players)
  localparam int JB_R      = 0;
  localparam int JB_L      = 1;
  localparam int JB_D      = 2;
  localparam int JB_U      = 3;
  localparam int JB_FIRE   = 4;
  localparam int JB_BOMB   = 5;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;
  localparam int JB_COIN   = 8;

  // Scan codes matched regardless of the extended prefix
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_BOMB  = 8'h14;

  // Full {ext,code} values that must match exactly
  localparam logic [8:0] KC_P1_FIRE  = 9'h029;
  localparam logic [8:0] KC_START1_A = 9'h005;
  localparam logic [8:0] KC_START1_B = 9'h016;
  localparam logic [8:0] KC_START2_A = 9'h006;
  localparam logic [8:0] KC_START2_B = 9'h01E;
  localparam logic [8:0] KC_COIN1    = 9'h02E;
  localparam logic [8:0] KC_COIN2    = 9'h036;
  localparam logic [8:0] KC_P2_UP    = 9'h02D;
  localparam logic [8:0] KC_P2_DOWN  = 9'h02B;
  localparam logic [8:0] KC_P2_LEFT  = 9'h023;
  localparam logic [8:0] KC_P2_RIGHT = 9'h034;
  localparam logic [8:0] KC_P2_FIRE  = 9'h01C;
  localparam logic [8:0] KC_P2_BOMB  = 9'h01B;

  // Bit positions inside the key-state register
  localparam int         NUM_KEYS   = 16;
  localparam logic [3:0] KI_P1_U    = 4'd0;
  localparam logic [3:0] KI_P1_D    = 4'd1;
  localparam logic [3:0] KI_P1_L    = 4'd2;
  localparam logic [3:0] KI_P1_R    = 4'd3;
  localparam logic [3:0] KI_P1_FIRE = 4'd4;
  localparam logic [3:0] KI_P1_BOMB = 4'd5;
  localparam logic [3:0] KI_START1  = 4'd6;
  localparam logic [3:0] KI_START2  = 4'd7;
  localparam logic [3:0] KI_COIN1   = 4'd8;
  localparam logic [3:0] KI_COIN2   = 4'd9;
  localparam logic [3:0] KI_P2_U    = 4'd10;
  localparam logic [3:0] KI_P2_D    = 4'd11;
  localparam logic [3:0] KI_P2_L    = 4'd12;
  localparam logic [3:0] KI_P2_R    = 4'd13;
  localparam logic [3:0] KI_P2_FIRE = 4'd14;
  localparam logic [3:0] KI_P2_BOMB = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  // Map a 9-bit {ext,code} to its key-state bit; hit=0 for unmapped codes.
  function automatic key_hit_t key_lookup(input logic [8:0] k);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 4'd0;
    case (k[7:0])
      SC_UP:    r.idx = KI_P1_U;
      SC_DOWN:  r.idx = KI_P1_D;
      SC_LEFT:  r.idx = KI_P1_L;
      SC_RIGHT: r.idx = KI_P1_R;
      SC_BOMB:  r.idx = KI_P1_BOMB;
      default: begin
        case (k)
          KC_P1_FIRE:               r.idx = KI_P1_FIRE;
          KC_START1_A, KC_START1_B: r.idx = KI_START1;
          KC_START2_A, KC_START2_B: r.idx = KI_START2;
          KC_COIN1:                 r.idx = KI_COIN1;
          KC_COIN2:                 r.idx = KI_COIN2;
          KC_P2_UP:                 r.idx = KI_P2_U;
          KC_P2_DOWN:               r.idx = KI_P2_D;
          KC_P2_LEFT:               r.idx = KI_P2_L;
          KC_P2_RIGHT:              r.idx = KI_P2_R;
          KC_P2_FIRE:               r.idx = KI_P2_FIRE;
          KC_P2_BOMB:               r.idx = KI_P2_BOMB;
          default:                  r.hit = 1'b0;
        endcase
      end
    endcase
    return r;
  endfunction

  // dir is {up,down,left,right}; opposing pairs held together cancel out.
  function automatic logic [3:0] socd_filter(input logic [3:0] dir, input logic en);
    logic [3:0] r;
    r = dir;
    if (en && dir[3] && dir[2]) r[3:2] = 2'b00;
    if (en && dir[1] && dir[0]) r[1:0] = 2'b00;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_joy_input_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : kbd_joy_input_ctrl_if                                         |
// | Purpose  : Bundles the raw player inputs and the conditioned controls.   |
// | Ports    : ps2_key[10:0], joy_0/joy_1[15:0], kbd_clear (to the block);   |
// |            p1_dir/p2_dir[3:0], p1_btn/p2_btn[1:0], start1, start2, coin  |
// |            (from the block). master = input source, slave = the block.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface kbd_joy_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joy_0;
  logic [15:0] joy_1;
  logic        kbd_clear;
  logic [3:0]  p1_dir;
  logic [1:0]  p1_btn;
  logic [3:0]  p2_dir;
  logic [1:0]  p2_btn;
  logic        start1;
  logic        start2;
  logic        coin;

  modport master (
    output ps2_key, joy_0, joy_1, kbd_clear,
    input  p1_dir, p1_btn, p2_dir, p2_btn, start1, start2, coin
  );

  modport slave (
    input  ps2_key, joy_0, joy_1, kbd_clear,
    output p1_dir, p1_btn, p2_dir, p2_btn, start1, start2, coin
  );
endinterface
`default_nettype wire

// File: rtl/kbd_joy_input_ctrl_coin_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : coin_pulse_gen                                                |
// | Purpose  : Turns the raw coin level into a pulse of at least             |
// |            COIN_MIN_CYC cycles followed by a COIN_GAP_CYC low gap; one   |
// |            extra coin arriving meanwhile is queued, more are dropped.    |
// | Ports    : clk_sys, reset_n (async, active-low), coin_raw (level),       |
// |            clr (drops a queued coin), coin (registered pulse out)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module coin_pulse_gen
  import input_pkg::*;
#(
  parameter int COIN_MIN_CYC = 1800000,
  parameter int COIN_GAP_CYC = 1800000
) (
  input  wire logic clk_sys,
  input  wire logic reset_n,
  input  wire logic coin_raw,
  input  wire logic clr,
  output logic      coin
);

  localparam int MAX_CYC = (COIN_MIN_CYC > COIN_GAP_CYC) ? COIN_MIN_CYC : COIN_GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(COIN_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(COIN_GAP_CYC - 1);

  coin_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             coin_q;
  logic             pend_q;
  logic             raw_q;
  logic             rise;

  assign rise = coin_raw & ~raw_q;
  assign coin = coin_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coin_q  <= 1'b0;
      pend_q  <= 1'b0;
      raw_q   <= 1'b0;
    end else begin
      raw_q <= coin_raw;
      // Queue a coin arriving while busy; a second one overwrites a set flag.
      if (rise && (state_q != IDLE)) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // A coin queued at the very end of a gap launches from here.
          if (rise || pend_q) begin
            state_q <= PULSE;
            cnt_q   <= MIN_LOAD;
            coin_q  <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
        PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!coin_raw) begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
            coin_q  <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (pend_q) begin
            // Consumes the queued coin; a rise on this same edge is dropped.
            state_q <= PULSE;
            cnt_q   <= MIN_LOAD;
            coin_q  <= 1'b1;
            pend_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          coin_q  <= 1'b0;
        end
      endcase
      if (clr) pend_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_joy_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : kbd_joy_input_ctrl                                            |
// | Purpose  : Decodes PS/2 key events into per-key state, merges them with  |
// |            both joystick words, cancels opposing directions and shapes   |
// |            the coin input. All player outputs are registered.            |
// | Ports    : clk_sys, reset_n (async, active-low), bus (slave modport:     |
// |            ps2_key/joy_0/joy_1/kbd_clear in, p1/p2 dir+btn, start1/2,    |
// |            coin out)                                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module kbd_joy_input_ctrl
  import input_pkg::*;
#(
  parameter int COIN_MIN_CYC = 1800000,
  parameter int COIN_GAP_CYC = 1800000,
  parameter int SOCD_NEUTRAL = 1
) (
  input  wire logic            clk_sys,
  input  wire logic            reset_n,
  kbd_joy_input_ctrl_if.slave  bus
);

  logic                tog_q, tog_d;
  logic                primed_q, primed_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [3:0]          p1_dir_q, p1_dir_d;
  logic [1:0]          p1_btn_q, p1_btn_d;
  logic [3:0]          p2_dir_q, p2_dir_d;
  logic [1:0]          p2_btn_q, p2_btn_d;
  logic                start1_q, start1_d;
  logic                start2_q, start2_d;
  logic                coin_raw;
  logic                coin_w;
  key_hit_t            lk;
  logic                unused_joy;

  assign unused_joy = ^{bus.joy_0[15:9], bus.joy_1[15:9]};

  // Key event decode. The first clock after reset only captures the toggle
  // level so a stale toggle state cannot be mistaken for an event.
  always_comb begin
    lk       = key_lookup(bus.ps2_key[8:0]);
    tog_d    = tog_q;
    key_d    = key_q;
    primed_d = 1'b1;
    if (!primed_q) begin
      tog_d = bus.ps2_key[10];
    end else if (bus.ps2_key[10] != tog_q) begin
      tog_d = bus.ps2_key[10];
      if (lk.hit) key_d[lk.idx] = bus.ps2_key[9];
    end
    // Clear wins over any event landing on the same edge.
    if (bus.kbd_clear) key_d = '0;
  end

  // Merge keyboard state with joysticks; directions are {up,down,left,right}.
  always_comb begin
    p1_dir_d = socd_filter({key_q[KI_P1_U] | bus.joy_0[JB_U],
                            key_q[KI_P1_D] | bus.joy_0[JB_D],
                            key_q[KI_P1_L] | bus.joy_0[JB_L],
                            key_q[KI_P1_R] | bus.joy_0[JB_R]}, SOCD_NEUTRAL != 0);
    p2_dir_d = socd_filter({key_q[KI_P2_U] | bus.joy_1[JB_U],
                            key_q[KI_P2_D] | bus.joy_1[JB_D],
                            key_q[KI_P2_L] | bus.joy_1[JB_L],
                            key_q[KI_P2_R] | bus.joy_1[JB_R]}, SOCD_NEUTRAL != 0);
    p1_btn_d = {key_q[KI_P1_BOMB] | bus.joy_0[JB_BOMB],
                key_q[KI_P1_FIRE] | bus.joy_0[JB_FIRE]};
    p2_btn_d = {key_q[KI_P2_BOMB] | bus.joy_1[JB_BOMB],
                key_q[KI_P2_FIRE] | bus.joy_1[JB_FIRE]};
    start1_d = key_q[KI_START1] | bus.joy_0[JB_START1] | bus.joy_1[JB_START1];
    start2_d = key_q[KI_START2] | bus.joy_0[JB_START2] | bus.joy_1[JB_START2];
    coin_raw = key_q[KI_COIN1] | key_q[KI_COIN2] | bus.joy_0[JB_COIN] | bus.joy_1[JB_COIN];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
      key_q    <= '0;
      p1_dir_q <= '0;
      p1_btn_q <= '0;
      p2_dir_q <= '0;
      p2_btn_q <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      tog_q    <= tog_d;
      primed_q <= primed_d;
      key_q    <= key_d;
      p1_dir_q <= p1_dir_d;
      p1_btn_q <= p1_btn_d;
      p2_dir_q <= p2_dir_d;
      p2_btn_q <= p2_btn_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
    end
  end

  coin_pulse_gen #(
    .COIN_MIN_CYC (COIN_MIN_CYC),
    .COIN_GAP_CYC (COIN_GAP_CYC)
  ) u_coin (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .coin_raw (coin_raw),
    .clr      (bus.kbd_clear),
    .coin     (coin_w)
  );

  assign bus.p1_dir = p1_dir_q;
  assign bus.p1_btn = p1_btn_q;
  assign bus.p2_dir = p2_dir_q;
  assign bus.p2_btn = p2_btn_q;
  assign bus.start1 = start1_q;
  assign bus.start2 = start2_q;
  assign bus.coin   = coin_w;

endmodule
`default_nettype wire

// File: tb/tb_kbd_joy_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_kbd_joy_input_ctrl                                         |
// | Purpose  : Directed self-checking bench for kbd_joy_input_ctrl with      |
// |            COIN_MIN_CYC=4, COIN_GAP_CYC=3; expectations queued at drive  |
// |            time and popped when the output is sampled.                   |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_kbd_joy_input_ctrl;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_item_t;

  logic     clk_sys;
  logic     reset_n;
  logic     tg;
  int       n_tests;
  int       n_fail;
  sb_item_t sb_q[$];

  kbd_joy_input_ctrl_if bus ();

  kbd_joy_input_ctrl #(
    .COIN_MIN_CYC (4),
    .COIN_GAP_CYC (3),
    .SOCD_NEUTRAL (1)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [3:0] e);
    sb_item_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic check(input logic [3:0] obs);
    sb_item_t it;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty observed=%b expected=<none>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
      end
    end
  endtask

  // One PS/2 event; returns after the two edges needed to reach the outputs.
  task automatic ps2_ev(input logic [8:0] code, input logic pressed);
    tg = ~tg;
    bus.ps2_key = {tg, pressed, code};
    step(2);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    tg            = 1'b1;
    bus.ps2_key   = {1'b1, 1'b1, 9'h029};
    bus.joy_0     = '0;
    bus.joy_1     = '0;
    bus.kbd_clear = 1'b0;
    step(2);

    // Reset state
    expect_val("rst_p1_btn", 4'd0); check({2'b00, bus.p1_btn});
    expect_val("rst_p1_dir", 4'd0); check(bus.p1_dir);
    expect_val("rst_coin",   4'd0); check({3'b000, bus.coin});
    expect_val("rst_start1", 4'd0); check({3'b000, bus.start1});

    // Priming: held toggle level at release is not an event
    reset_n = 1'b1;
    expect_val("prime_no_fire", 4'd0);
    step(3);
    check({2'b00, bus.p1_btn});

    tg = 1'b0;
    bus.ps2_key = {tg, 1'b1, 9'h029};
    expect_val("fire_one_edge", 4'd0);
    step(1); check({2'b00, bus.p1_btn});
    expect_val("fire_on", 4'b0001);
    step(1); check({2'b00, bus.p1_btn});
    expect_val("fire_off", 4'd0);
    ps2_ev(9'h029, 1'b0); check({2'b00, bus.p1_btn});

    // Extended arrows and direction cancellation
    expect_val("ext_up", 4'b1000);
    ps2_ev(9'h175, 1'b1); check(bus.p1_dir);
    expect_val("socd_ud", 4'b0000);
    ps2_ev(9'h072, 1'b1); check(bus.p1_dir);
    expect_val("rel_up_down", 4'b0100);
    ps2_ev(9'h175, 1'b0); check(bus.p1_dir);
    expect_val("rel_down", 4'b0000);
    ps2_ev(9'h072, 1'b0); check(bus.p1_dir);

    // Merge
    bus.joy_1 = 16'h0011;
    expect_val("merge_p2_dir", 4'b0001);
    expect_val("merge_p2_btn", 4'b0011);
    ps2_ev(9'h01B, 1'b1);
    check(bus.p2_dir);
    check({2'b00, bus.p2_btn});
    bus.joy_0 = 16'h0040;
    expect_val("joy_start1", 4'b0001);
    step(1); check({3'b000, bus.start1});
    bus.joy_0 = 16'h0009;
    expect_val("joy_p1_ur", 4'b1001);
    expect_val("start1_off", 4'd0);
    step(1); check(bus.p1_dir); check({3'b000, bus.start1});
    bus.joy_0 = '0;
    bus.joy_1 = '0;
    expect_val("p2_btn_clear", 4'd0);
    ps2_ev(9'h01B, 1'b0); check({2'b00, bus.p2_btn});

    // Coin short press, queued second press, dropped third press
    expect_val("coin_idle", 4'd0); check({3'b000, bus.coin});
    bus.joy_0 = 16'h0100;
    expect_val("c1_pulse0", 4'd1);
    step(1); check({3'b000, bus.coin});
    bus.joy_0 = '0;
    for (int i = 1; i < 4; i++) begin
      expect_val("c1_pulse", 4'd1);
      step(1); check({3'b000, bus.coin});
    end
    expect_val("c1_gap0", 4'd0);
    step(1); check({3'b000, bus.coin});
    bus.joy_0 = 16'h0100;
    expect_val("c1_gap1", 4'd0);
    step(1); check({3'b000, bus.coin});
    bus.joy_0 = '0;
    expect_val("c1_gap2", 4'd0);
    step(1); check({3'b000, bus.coin});
    bus.joy_0 = 16'h0100;
    expect_val("c2_pulse0", 4'd1);
    step(1); check({3'b000, bus.coin});
    bus.joy_0 = '0;
    for (int i = 1; i < 4; i++) begin
      expect_val("c2_pulse", 4'd1);
      step(1); check({3'b000, bus.coin});
    end
    for (int i = 0; i < 6; i++) begin
      expect_val("c2_gap_no_third", 4'd0);
      step(1); check({3'b000, bus.coin});
    end

    // Coin held via keyboard: pulse stretches until release
    expect_val("held_on", 4'd1);
    ps2_ev(9'h02E, 1'b1); check({3'b000, bus.coin});
    for (int i = 0; i < 8; i++) begin
      expect_val("held_hold", 4'd1);
      step(1); check({3'b000, bus.coin});
    end
    tg = ~tg;
    bus.ps2_key = {tg, 1'b0, 9'h02E};
    expect_val("held_rel_edge", 4'd1);
    step(1); check({3'b000, bus.coin});
    for (int i = 0; i < 4; i++) begin
      expect_val("held_gap", 4'd0);
      step(1); check({3'b000, bus.coin});
    end

    // kbd_clear
    ps2_ev(9'h075, 1'b1);
    expect_val("clr_pre_dir", 4'b1000);
    expect_val("clr_pre_btn", 4'b0001);
    ps2_ev(9'h01C, 1'b1);
    check(bus.p1_dir); check({2'b00, bus.p2_btn});
    bus.kbd_clear = 1'b1;
    expect_val("clr_one_edge", 4'b1000);
    step(1); check(bus.p1_dir);
    bus.kbd_clear = 1'b0;
    expect_val("clr_dir", 4'd0);
    expect_val("clr_btn", 4'd0);
    step(1); check(bus.p1_dir); check({2'b00, bus.p2_btn});

    // Asynchronous reset in the middle of a coin pulse
    bus.joy_0 = 16'h0100;
    expect_val("rstp_pulse0", 4'd1);
    step(1); check({3'b000, bus.coin});
    bus.joy_0 = '0;
    expect_val("rstp_pulse1", 4'd1);
    step(1); check({3'b000, bus.coin});
    #2;
    reset_n = 1'b0;
    expect_val("rstp_coin_async", 4'd0);
    #1;
    check({3'b000, bus.coin});
    step(1);
    reset_n = 1'b1;
    expect_val("rstp_after_prime", 4'd0);
    step(2); check({3'b000, bus.coin});
    expect_val("rstp_fire", 4'b0001);
    ps2_ev(9'h029, 1'b1); check({2'b00, bus.p1_btn});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
